// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - sequential unsigned MUL/DIVU that borrows a shared single-cycle ALU
// Shift-add multiply and restoring divide, one ALU operation per granted cycle.
module alu_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic [XLEN-1:0] resp_rem,
  output logic            alu_req,
  input  logic            alu_gnt,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_res
);

  localparam int CW = $clog2(XLEN);
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_IDLE = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE, S_MUL_STEP, S_DIV_CMP, S_DIV_SUB, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            op_q, op_d;
  // a: multiplicand (MUL) / quotient (DIVU); b: multiplier / divisor; acc: product / remainder
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [XLEN-1:0] shift_s;
  logic            ovf_s;
  logic            cnt_last_s;
  logic            adv_s;

  assign shift_s    = {acc_q[XLEN-2:0], a_q[XLEN-1]};
  assign ovf_s      = acc_q[XLEN-1];
  assign cnt_last_s = (cnt_q == CW'(XLEN-1));
  assign adv_s      = alu_gnt && !flush;

  assign resp_result = op_q ? a_q : acc_q;
  assign resp_rem    = op_q ? acc_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_DONE);
    alu_req    = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_ctrl   = ALU_IDLE;

    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          op_d  = req_op;
          cnt_d = '0;
          a_d   = req_a;
          b_d   = req_b;
          acc_d = '0;
          if (!req_op) begin
            state_d = (req_b == '0) ? S_DONE : S_MUL_STEP;
          end else if (req_b == '0) begin
            a_d     = '1;
            acc_d   = req_a;
            state_d = S_DONE;
          end else begin
            state_d = S_DIV_CMP;
          end
        end
      end

      S_MUL_STEP: begin
        alu_req  = 1'b1;
        alu_ctrl = ALU_ADD;
        alu_a    = acc_q;
        alu_b    = b_q[0] ? a_q : '0;
        if (adv_s) begin
          acc_d = alu_res;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          if ((b_q >> 1) == '0 || cnt_last_s) state_d = S_DONE;
          else                                cnt_d   = cnt_q + 1'b1;
        end
      end

      S_DIV_CMP: begin
        alu_req  = 1'b1;
        alu_ctrl = ALU_SLTU;
        alu_a    = shift_s;
        alu_b    = b_q;
        if (adv_s) begin
          acc_d = shift_s;
          a_d   = a_q << 1;
          // A bit shifted out of rem means the true partial remainder exceeds any divisor.
          if (!ovf_s && alu_res[0]) begin
            if (cnt_last_s) state_d = S_DONE;
            else            cnt_d   = cnt_q + 1'b1;
          end else begin
            state_d = S_DIV_SUB;
          end
        end
      end

      S_DIV_SUB: begin
        alu_req  = 1'b1;
        alu_ctrl = ALU_SUB;
        alu_a    = acc_q;
        alu_b    = b_q;
        if (adv_s) begin
          acc_d    = alu_res;
          a_d[0]   = 1'b1;
          if (cnt_last_s) state_d = S_DONE;
          else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_DIV_CMP;
          end
        end
      end

      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (flush) state_d = S_IDLE;
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - directed self-checking bench for alu_muldiv_seq
// Results and latencies come from a plain-arithmetic model pinned by literal expectations.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_op = 1'b0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_result;
  logic [31:0] resp_rem;
  logic        alu_req;
  logic        alu_gnt = 1'b1;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_res;

  int checks = 0;
  int errors = 0;

  logic        exp_valid = 1'b0;
  logic [31:0] exp_res = '0;
  logic [31:0] exp_rem = '0;

  always #5 clk = ~clk;

  assign alu_res = (alu_ctrl == 4'b0010) ? alu_a + alu_b :
                   (alu_ctrl == 4'b0100) ? alu_a - alu_b :
                   (alu_ctrl == 4'b0110) ? {31'd0, alu_a < alu_b} : 32'd0;

  alu_muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_rem(resp_rem),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_res(alu_res)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Latency counts rising edges from the accept edge to the first edge after which resp_valid is high.
  function automatic void model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [31:0] m, output int lat);
    int hsb;
    if (b == 0) begin
      r   = op ? 32'hFFFF_FFFF : 32'd0;
      m   = op ? a : 32'd0;
      lat = 1;
    end else if (!op) begin
      r   = a * b;
      m   = 32'd0;
      hsb = 0;
      for (int i = 0; i < 32; i++) if (b[i]) hsb = i;
      lat = hsb + 2;
    end else begin
      r   = a / b;
      m   = a % b;
      lat = 1 + 32 + $countones(r);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("alu_req_vs_ctrl", {31'd0, alu_req}, {31'd0, alu_ctrl != 4'hF});
      if (exp_valid && resp_valid) begin
        check("resp_result", resp_result, exp_res);
        check("resp_rem", resp_rem, exp_rem);
      end
      if (!exp_valid) check("no_spurious_resp", {31'd0, resp_valid}, 32'd0);
    end
  end

  task automatic accept(input logic op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit_res, input logic [31:0] lit_rem, input int lit_lat,
                        input int stall_at, input int stall_len, input int hold);
    logic [31:0] mr, mm, ca, cb;
    logic [3:0]  cc;
    int          mlat, edges;
    logic        used_alu;
    model(op, a, b, mr, mm, mlat);
    check("model_res_pin", mr, lit_res);
    check("model_rem_pin", mm, lit_rem);
    check("model_lat_pin", mlat, lit_lat);
    exp_res = mr; exp_rem = mm; exp_valid = 1'b1;
    accept(op, a, b);
    edges = 1;
    used_alu = 1'b0;
    while (resp_valid !== 1'b1 && edges < 300) begin
      if (edges == stall_at) begin
        alu_gnt = 1'b0;
        ca = alu_a; cb = alu_b; cc = alu_ctrl;
        for (int k = 0; k < stall_len; k++) begin
          @(posedge clk); #1;
          edges++;
          check("stall_alu_req", {31'd0, alu_req}, 32'd1);
          check("stall_alu_a", alu_a, ca);
          check("stall_alu_b", alu_b, cb);
          check("stall_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, cc});
        end
        alu_gnt = 1'b1;
      end else begin
        if (alu_req) used_alu = 1'b1;
        @(posedge clk); #1;
        edges++;
      end
    end
    check("latency", edges, mlat + ((stall_at > 0) ? stall_len : 0));
    if (op && b == 0) check("div0_no_alu_req", {31'd0, used_alu}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("resp_held", {31'd0, resp_valid}, 32'd1);
      check("req_ready_busy", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    exp_valid = 1'b0;
    check("resp_cleared", {31'd0, resp_valid}, 32'd0);
    check("back_idle", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #2;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_alu_req", {31'd0, alu_req}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'hF);
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 32'd6, 32'd7, 32'd42, 32'd0, 4, 0, 0, 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 33, 0, 0, 0);
    run_op(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 36, 0, 0, 0);
    run_op(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, 0, 0, 0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 34, 0, 0, 0);
    run_op(1'b0, 32'd6, 32'd7, 32'd42, 32'd0, 4, 2, 3, 0);
    run_op(1'b0, 32'd123, 32'd0, 32'd0, 32'd0, 1, 0, 0, 0);
    run_op(1'b0, 32'h0001_0000, 32'h8000_0000, 32'd0, 32'd0, 33, 0, 0, 0);
    run_op(1'b1, 32'd7, 32'd9, 32'd0, 32'd7, 33, 0, 0, 0);

    // Flush while dividing: nothing comes back, sequencer is idle again.
    exp_valid = 1'b0;
    accept(1'b1, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #1;
    check("pre_flush_busy", {31'd0, alu_req}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", {31'd0, req_ready}, 32'd1);
    check("flush_no_alu", {31'd0, alu_req}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("flush_still_idle", {31'd0, req_ready}, 32'd1);

    run_op(1'b1, 32'd1000, 32'd33, 32'd30, 32'd10, 37, 0, 0, 4);

    // Asynchronous reset in the middle of a long multiply.
    accept(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midop_rst_ready", {31'd0, req_ready}, 32'd1);
    check("midop_rst_alu_req", {31'd0, alu_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 32'd13, 32'd11, 32'd143, 32'd0, 5, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
